btn_event_decoder: RTL and testbench
====================================

Name: btn_event_decoder

Overview:
- Sits directly downstream of the button debouncer and consumes its clean, debounced level.
- Converts that level into single-cycle event pulses: press, release, short press, long press and double click. It also drives a held level.
- Events feed the control/UI logic, so consumers never time button levels themselves.
- Timing uses an internal prescaled tick, so thresholds are given in ticks, not clocks.

Parameters:
- TICK_DIV, 4, clk cycles per timing tick (>=1)
- LONG_TICKS, 5, ticks a press must last to count as a long press (>=1)
- DCLICK_TICKS, 3, ticks allowed between the first release and the second press for a double click (>=1)
- CNT_W, 8, width of the tick and hold counters; must hold max(TICK_DIV, LONG_TICKS, DCLICK_TICKS)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- db_in  input  1  debounced button level from the debouncer (1 = pressed)
- press_pulse  output  1  one-cycle pulse on each debounced rising edge
- release_pulse  output  1  one-cycle pulse on each debounced falling edge
- short_press  output  1  one-cycle pulse: a single press released before LONG_TICKS, with no second press in time
- long_press  output  1  one-cycle pulse when a press reaches LONG_TICKS; still held
- double_click  output  1  one-cycle pulse on release of the second press of a double click
- held  output  1  level; equals the registered db_in

Behaviour:
- Reset
  - Asynchronous and active-high.
  - All outputs go to 0. db_q, prescaler and hold counter clear to 0. State goes to IDLE.
  - Reset mid-sequence discards any pending event.
  - After reset, a db_in already at 1 is NOT a press; db_q loads 1 on the first clock and no rise is seen.
- Edge detection
  - db_q is db_in registered.
  - rise = db_in & ~db_q; fall = ~db_in & db_q.
  - All outputs are registered.
  - press_pulse / release_pulse are high for exactly 1 cycle, starting at the clock edge after the one where db_q first differs from db_in.
  - held = db_q.
- Timing
  - The prescaler counts 0..TICK_DIV-1; tick is high in the cycle it equals TICK_DIV-1, and it then wraps.
  - hold_cnt increments on tick and saturates at all-ones.
  - On every state transition, the prescaler and hold_cnt clear to 0. Clearing takes precedence over the increment.
  - Thresholds are therefore exact: a threshold of T ticks is reached T*TICK_DIV cycles after state entry.
- State machine
  - IDLE:
    - rise -> PRESSED.
  - PRESSED:
    - fall -> WAIT2.
    - else, tick with hold_cnt == LONG_TICKS-1 -> LONG_HELD; long_press pulses.
    - fall wins over a simultaneous threshold.
  - LONG_HELD:
    - fall -> IDLE.
    - No short_press or double_click is issued.
  - WAIT2:
    - rise -> PRESS2.
    - else, tick with hold_cnt == DCLICK_TICKS-1 -> IDLE; short_press pulses.
    - rise wins over a simultaneous timeout.
  - PRESS2:
    - fall -> IDLE; double_click pulses.
    - else, reaching LONG_TICKS -> LONG_HELD; long_press pulses and there is no double_click.
- Pulses stay orthogonal: press_pulse / release_pulse fire on every edge, regardless of state.
  - Example: a double click yields 2 press_pulse, 2 release_pulse and 1 double_click.
- Event pulses are issued on the same clock edge as the transition that causes them. Each pulse lasts 1 cycle.
- Unreachable state encodings return to IDLE with no pulse.

Decomposition:
- Package btn_pkg holds:
  - the typedef enum logic [2:0] for states IDLE, PRESSED, LONG_HELD, WAIT2, PRESS2;
  - the default tick constants.
- One sub-module is natural: btn_tick_timer, a prescaler plus saturating tick counter with a synchronous clear input.
- The edge detector and FSM stay in the top module.

Test Plan:
All scenarios use the defaults: TICK_DIV=4, LONG_TICKS=5, DCLICK_TICKS=3.
- Short press: db_in high for 8 cycles, then low.
  - press_pulse and release_pulse each pulse once.
  - short_press pulses 12 cycles after the WAIT2 entry.
  - No long_press or double_click.
- Long press: db_in high for 30 cycles.
  - long_press pulses once, exactly 20 cycles after PRESSED entry.
  - The later release gives release_pulse only; short_press stays 0.
- Double click: high 6 cycles, low 5, high 6, low.
  - double_click pulses once, on the edge of the second release's transition.
  - short_press stays 0.
- Boundary: the gap between presses equals exactly 12 cycles, so the rise coincides with the timeout tick.
  - Rise wins: PRESS2 is entered and a double_click follows; no short_press.
  - A gap of 13 cycles gives short_press, and the second press starts a new sequence.
- Reset mid-operation: assert reset while in PRESSED after 10 cycles, with db_in held high.
  - All outputs are 0 immediately.
  - After deassertion, no press_pulse and no long_press occur until db_in goes low and then high again.

Source files
------------

// File: rtl/btn_event_decoder_pkg.sv
// Shared types and default timing constants for the button event decoder.
package btn_pkg;

   // Decoder states; the three spare 3-bit encodings are treated as illegal.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRESSED   = 3'd1,
      LONG_HELD = 3'd2,
      WAIT2     = 3'd3,
      PRESS2    = 3'd4
   } btn_state_e;

   localparam int DEF_TICK_DIV     = 4;
   localparam int DEF_LONG_TICKS   = 5;
   localparam int DEF_DCLICK_TICKS = 3;
   localparam int DEF_CNT_W        = 8;

endpackage

// File: rtl/btn_event_decoder_if.sv
// Button level in, event pulses and held level out.
interface btn_event_if;
   logic db_in;
   logic press_pulse;
   logic release_pulse;
   logic short_press;
   logic long_press;
   logic double_click;
   logic held;

   // Source of the debounced level; consumes the events.
   modport master (
      output db_in,
      input  press_pulse, release_pulse, short_press, long_press, double_click, held
   );

   // The decoder itself.
   modport slave (
      input  db_in,
      output press_pulse, release_pulse, short_press, long_press, double_click, held
   );
endinterface

// File: rtl/btn_event_decoder_tick_timer.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks, plus a
// saturating count of ticks. A synchronous clear restarts both so that
// thresholds measured from the clear are exact multiples of TICK_DIV.
module btn_tick_timer import btn_pkg::*; #(
   parameter int TICK_DIV = DEF_TICK_DIV,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   output logic             tick_o,
   output logic [CNT_W-1:0] hold_cnt_o
);

   logic [CNT_W-1:0] presc_q;
   logic [CNT_W-1:0] hold_q;

   assign tick_o     = (presc_q == CNT_W'(TICK_DIV - 1));
   assign hold_cnt_o = hold_q;

   // Prescaler wraps on tick; hold count saturates; clear beats both.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q <= '0;
         hold_q  <= '0;
      end else if (clr_i) begin
         presc_q <= '0;
         hold_q  <= '0;
      end else begin
         presc_q <= tick_o ? '0 : presc_q + 1'b1;
         if (tick_o && (hold_q != '1))
            hold_q <= hold_q + 1'b1;
      end
   end

endmodule

// File: rtl/btn_event_decoder.sv
// Turns a debounced button level into press/release/short/long/double-click
// pulses and a held level. All outputs are registered; event pulses appear
// on the same edge as the state change that causes them.
module btn_event_decoder import btn_pkg::*; #(
   parameter int TICK_DIV     = DEF_TICK_DIV,
   parameter int LONG_TICKS   = DEF_LONG_TICKS,
   parameter int DCLICK_TICKS = DEF_DCLICK_TICKS,
   parameter int CNT_W        = DEF_CNT_W
) (
   input logic        clk,
   input logic        reset,
   btn_event_if.slave bus
);

   logic             db_q;
   logic             armed_q;
   logic             rise;
   logic             fall;
   logic             tick;
   logic             clr;
   logic             long_hit;
   logic             dclick_to;
   logic [CNT_W-1:0] hold_cnt;

   btn_state_e state_q, state_d;
   logic       long_d, short_d, dclick_d;
   logic       press_q, release_q, short_q, long_q, dclick_q;

   // armed_q masks the first clock after reset, so a button already held
   // through reset is not reported as a fresh press.
   assign rise      = armed_q &  bus.db_in & ~db_q;
   assign fall      = armed_q & ~bus.db_in &  db_q;
   assign long_hit  = tick && (hold_cnt == CNT_W'(LONG_TICKS - 1));
   assign dclick_to = tick && (hold_cnt == CNT_W'(DCLICK_TICKS - 1));

   // Every state change restarts the timer so each state times from entry.
   assign clr = (state_d != state_q);

   btn_tick_timer #(
      .TICK_DIV (TICK_DIV),
      .CNT_W    (CNT_W)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (clr),
      .tick_o     (tick),
      .hold_cnt_o (hold_cnt)
   );

   // Next-state and event decode; edges take priority over timeouts.
   always_comb begin
      state_d  = state_q;
      long_d   = 1'b0;
      short_d  = 1'b0;
      dclick_d = 1'b0;
      case (state_q)
         IDLE:      if (rise) state_d = PRESSED;
         PRESSED: begin
            if (fall)          state_d = WAIT2;
            else if (long_hit) begin state_d = LONG_HELD; long_d = 1'b1; end
         end
         LONG_HELD: if (fall) state_d = IDLE;
         WAIT2: begin
            if (rise)           state_d = PRESS2;
            else if (dclick_to) begin state_d = IDLE; short_d = 1'b1; end
         end
         PRESS2: begin
            if (fall)          begin state_d = IDLE; dclick_d = 1'b1; end
            else if (long_hit) begin state_d = LONG_HELD; long_d = 1'b1; end
         end
         default:   state_d = IDLE;
      endcase
   end

   // State, input sample and registered output pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db_q      <= 1'b0;
         armed_q   <= 1'b0;
         state_q   <= IDLE;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         short_q   <= 1'b0;
         long_q    <= 1'b0;
         dclick_q  <= 1'b0;
      end else begin
         db_q      <= bus.db_in;
         armed_q   <= 1'b1;
         state_q   <= state_d;
         press_q   <= rise;
         release_q <= fall;
         short_q   <= short_d;
         long_q    <= long_d;
         dclick_q  <= dclick_d;
      end
   end

   assign bus.press_pulse   = press_q;
   assign bus.release_pulse = release_q;
   assign bus.short_press   = short_q;
   assign bus.long_press    = long_q;
   assign bus.double_click  = dclick_q;
   assign bus.held          = db_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Scoreboard bench: the driver predicts each cycle's outputs from a
// time-since-entry model and queues them; the monitor compares after each edge.
module tb_btn_event_decoder;
   import btn_pkg::*;

   localparam int TD = 4;
   localparam int LT = 5;
   localparam int DT = 3;

   typedef struct packed {
      logic pr; logic rl; logic sp; logic lp; logic dc; logic hd;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   btn_event_if bus ();

   btn_event_decoder #(
      .TICK_DIV(TD), .LONG_TICKS(LT), .DCLICK_TICKS(DT), .CNT_W(8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   exp_t sbq[$];
   int   checks = 0;
   int   failures = 0;
   int   n_pr = 0, n_rl = 0, n_sp = 0, n_lp = 0, n_dc = 0;

   // Reference model: phase of the gesture plus edge index of phase entry.
   int k = 0, te = 0, ph = 0;
   bit mp = 1'b0, armed = 1'b0;

   function automatic exp_t outs();
      exp_t g;
      g = {bus.press_pulse, bus.release_pulse, bus.short_press,
           bus.long_press, bus.double_click, bus.held};
      return g;
   endfunction

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   // Drive one sampled level and queue the outputs expected after the edge.
   task automatic cyc(input bit v);
      exp_t e;
      bit   rise, fall;
      int   el;
      bus.db_in = v;
      rise = armed && v && !mp;
      fall = armed && !v && mp;
      e = '0; e.pr = rise; e.rl = fall; e.hd = v;
      el = k - te;
      case (ph)
         0: if (rise) begin ph = 1; te = k; end
         1: if (fall) begin ph = 3; te = k; end
            else if (el == LT*TD) begin ph = 2; te = k; e.lp = 1; end
         2: if (fall) begin ph = 0; te = k; end
         3: if (rise) begin ph = 4; te = k; end
            else if (el == DT*TD) begin ph = 0; te = k; e.sp = 1; end
         4: if (fall) begin ph = 0; te = k; e.dc = 1; end
            else if (el == LT*TD) begin ph = 2; te = k; e.lp = 1; end
         default: ph = 0;
      endcase
      mp = v; armed = 1'b1; k++;
      sbq.push_back(e);
      @(negedge clk);
   endtask

   task automatic run(input bit v, input int n);
      repeat (n) cyc(v);
   endtask

   task automatic clr_cnt();
      n_pr = 0; n_rl = 0; n_sp = 0; n_lp = 0; n_dc = 0;
   endtask

   task automatic do_reset();
      #1 reset = 1'b1;
      #1 chk("reset_async_outs", int'(outs()), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      mp = 1'b0; armed = 1'b0; ph = 0; te = k;
   endtask

   // Monitor: compare DUT outputs with the queued prediction after each edge.
   always @(posedge clk) begin
      exp_t e, g;
      #1;
      if (!reset) begin
         g = outs();
         checks++;
         if (sbq.size() == 0) begin
            failures++;
            $display("FAIL sb_underflow: got %b with no expectation queued", g);
         end else begin
            e = sbq.pop_front();
            if (g !== e) begin
               failures++;
               $display("FAIL sb_cycle t=%0t: got pr/rl/sp/lp/dc/hd=%b expected %b", $time, g, e);
            end
         end
         n_pr += int'(g.pr); n_rl += int'(g.rl); n_sp += int'(g.sp);
         n_lp += int'(g.lp); n_dc += int'(g.dc);
      end
   end

   initial begin
      bus.db_in = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outs", int'(outs()), 0);
      reset = 1'b0;

      run(0, 5);

      // Short press
      clr_cnt(); run(1, 8); run(0, 20);
      chk("short_press_n", n_pr, 1); chk("short_release_n", n_rl, 1);
      chk("short_sp_n", n_sp, 1); chk("short_lp_n", n_lp, 0); chk("short_dc_n", n_dc, 0);

      // Long press
      clr_cnt(); run(1, 30); run(0, 20);
      chk("long_lp_n", n_lp, 1); chk("long_sp_n", n_sp, 0);
      chk("long_release_n", n_rl, 1); chk("long_dc_n", n_dc, 0);

      // Double click
      clr_cnt(); run(1, 6); run(0, 5); run(1, 6); run(0, 20);
      chk("dbl_dc_n", n_dc, 1); chk("dbl_sp_n", n_sp, 0);
      chk("dbl_press_n", n_pr, 2); chk("dbl_release_n", n_rl, 2);

      // Second press lands on the timeout tick: rise wins
      clr_cnt(); run(1, 6); run(0, 12); run(1, 6); run(0, 20);
      chk("gap12_dc_n", n_dc, 1); chk("gap12_sp_n", n_sp, 0);

      // One cycle later: timeout fires, second press is a new gesture
      clr_cnt(); run(1, 6); run(0, 13); run(1, 6); run(0, 20);
      chk("gap13_dc_n", n_dc, 0); chk("gap13_sp_n", n_sp, 2);

      // Reset mid-press with the button still down
      run(1, 10);
      do_reset();
      clr_cnt(); run(1, 30);
      chk("rst_held_press_n", n_pr, 0); chk("rst_held_lp_n", n_lp, 0);
      clr_cnt(); run(0, 5); run(1, 25); run(0, 20);
      chk("rst_after_press_n", n_pr, 1); chk("rst_after_lp_n", n_lp, 1);

      // Random bursts, occasional reset
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 40) == 0) do_reset();
         run(1'($urandom_range(0, 1)), $urandom_range(1, 28));
      end
      run(0, 30);

      chk("sb_drained", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
